// File: rtl/packet_rx_checker.sv
// Serial frame receiver: start, mode, 32-bit payload (MSB first), CRC-8, stop; recomputes CRC-8 over the payload.
// Latency: result pulses are one cycle after the stop-bit sample. No backpressure; the line is sampled on each enabled cycle.
module packet_rx_checker #(
    parameter logic [7:0] CRC_POLY = 8'h07,
    parameter logic [7:0] CRC_INIT = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        packet_in,
    output logic [31:0] rx_data,
    output logic        rx_mode,
    output logic [7:0]  rx_crc,
    output logic        rx_valid,
    output logic        crc_err,
    output logic        frame_err,
    output logic        busy,
    output logic [15:0] ok_count,
    output logic [7:0]  err_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MODE,
        S_DATA,
        S_CRC,
        S_STOP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_bit_cnt;
    logic [5:0]  w_bit_cnt_nxt;
    logic [31:0] r_sh_data;
    logic        r_sh_mode;
    logic [7:0]  r_sh_crc;
    logic [7:0]  r_crc;
    logic [7:0]  w_crc_nxt;
    logic        w_crc_bad;
    logic        w_stop_good;
    logic        w_stop_bad;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

    assign w_crc_nxt = crc8_step(r_crc, packet_in);
    assign w_crc_bad = (r_crc != r_sh_crc);
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_stop_good   = 1'b0;
        w_stop_bad    = 1'b0;
        if (enable) begin
            case (r_state)
                S_IDLE: begin
                    if (!packet_in) w_state_nxt = S_MODE;
                end
                S_MODE: begin
                    w_state_nxt   = S_DATA;
                    w_bit_cnt_nxt = '0;
                end
                S_DATA: begin
                    if (r_bit_cnt == 6'd31) begin
                        w_state_nxt   = S_CRC;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 6'd1;
                    end
                end
                S_CRC: begin
                    if (r_bit_cnt == 6'd7) begin
                        w_state_nxt   = S_STOP;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 6'd1;
                    end
                end
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    w_stop_good = packet_in;
                    w_stop_bad  = !packet_in;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh_data <= '0;
            r_sh_mode <= 1'b0;
            r_sh_crc  <= '0;
            r_crc     <= '0;
            rx_data   <= '0;
            rx_mode   <= 1'b0;
            rx_crc    <= '0;
            rx_valid  <= 1'b0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
            ok_count  <= '0;
            err_count <= '0;
        end else begin
            // Result strobes are single-cycle whether or not the next cycle is enabled.
            rx_valid  <= 1'b0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
            if (enable) begin
                case (r_state)
                    S_IDLE: if (!packet_in) r_crc <= CRC_INIT;
                    S_MODE: r_sh_mode <= packet_in;
                    S_DATA: begin
                        r_sh_data <= {r_sh_data[30:0], packet_in};
                        r_crc     <= w_crc_nxt;
                    end
                    S_CRC:  r_sh_crc <= {r_sh_crc[6:0], packet_in};
                    default: ;
                endcase
            end
            if (w_stop_good) begin
                rx_data  <= r_sh_data;
                rx_mode  <= r_sh_mode;
                rx_crc   <= r_sh_crc;
                rx_valid <= 1'b1;
                crc_err  <= w_crc_bad;
                if (w_crc_bad) begin
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                end else begin
                    if (ok_count != 16'hFFFF) ok_count <= ok_count + 16'd1;
                end
            end
            if (w_stop_bad) begin
                frame_err <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_packet_rx_checker.sv
// Directed bench for packet_rx_checker: inputs driven and outputs sampled on the falling edge.
module tb_packet_rx_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        packet_in = 1'b1;
    logic [31:0] rx_data;
    logic        rx_mode;
    logic [7:0]  rx_crc;
    logic        rx_valid;
    logic        crc_err;
    logic        frame_err;
    logic        busy;
    logic [15:0] ok_count;
    logic [7:0]  err_count;

    int n_total = 0;
    int n_pass  = 0;
    int n_early = 0;
    logic busy_after_start = 1'b0;

    always #5 clk = ~clk;

    packet_rx_checker #(.CRC_POLY(8'h07), .CRC_INIT(8'h00)) dut (
        .clk(clk), .reset(reset), .enable(enable), .packet_in(packet_in),
        .rx_data(rx_data), .rx_mode(rx_mode), .rx_crc(rx_crc),
        .rx_valid(rx_valid), .crc_err(crc_err), .frame_err(frame_err),
        .busy(busy), .ok_count(ok_count), .err_count(err_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Apply one input pair across one rising edge; returns at the next falling edge.
    task automatic drive(input logic b, input logic en);
        packet_in = b;
        enable    = en;
        @(negedge clk);
    endtask

    // Sends a frame; with rand_en, junk-carrying disabled cycles are inserted before bits.
    // Returns right after the edge that samples the stop bit.
    task automatic send_frame(input logic mode, input logic [31:0] data, input logic [7:0] crc,
                              input logic stop, input logic rand_en);
        logic [42:0] f;
        f = {1'b0, mode, data, crc, stop};
        for (int i = 42; i >= 0; i--) begin
            if (rand_en) begin
                for (int g = 0; g < 8 && $urandom_range(0, 1) == 0; g++)
                    drive(1'($urandom_range(0, 1)), 1'b0);
            end
            drive(f[i], 1'b1);
            if (i == 42) busy_after_start = busy;
            if (i != 0 && (rx_valid || frame_err)) n_early++;
        end
    endtask

    initial begin
        int bad;
        logic [42:0] f;
        repeat (3) @(negedge clk);
        chk("reset_rx_data", rx_data, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_ok", {16'h0, ok_count}, 32'h0);
        chk("reset_err", {24'h0, err_count}, 32'h0);
        chk("reset_valid", {31'h0, rx_valid}, 32'h0);
        reset = 1'b0;

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 1'b1);
            if (busy || rx_valid || frame_err || crc_err) bad++;
        end
        chk("idle_activity", bad, 0);
        chk("idle_counts", {ok_count, 8'h0, err_count}, 32'h0);

        send_frame(1'b1, 32'h00000001, 8'h07, 1'b1, 1'b0);
        chk("f1_busy_start", {31'h0, busy_after_start}, 32'h1);
        chk("f1_valid", {31'h0, rx_valid}, 32'h1);
        chk("f1_busy_end", {31'h0, busy}, 32'h0);
        chk("f1_data", rx_data, 32'h00000001);
        chk("f1_mode", {31'h0, rx_mode}, 32'h1);
        chk("f1_crc_err", {31'h0, crc_err}, 32'h0);
        chk("f1_ok", {16'h0, ok_count}, 32'd1);
        drive(1'b1, 1'b1);
        chk("f1_valid_drop", {31'h0, rx_valid}, 32'h0);

        send_frame(1'b0, 32'h00000080, 8'h89, 1'b1, 1'b0);
        chk("b2b_a_valid", {31'h0, rx_valid}, 32'h1);
        chk("b2b_a_crc_err", {31'h0, crc_err}, 32'h0);
        chk("b2b_a_ok", {16'h0, ok_count}, 32'd2);
        send_frame(1'b0, 32'h00000080, 8'h88, 1'b1, 1'b0);
        chk("b2b_b_valid", {31'h0, rx_valid}, 32'h1);
        chk("b2b_b_crc_err", {31'h0, crc_err}, 32'h1);
        chk("b2b_b_rx_crc", {24'h0, rx_crc}, 32'h88);
        chk("b2b_b_err", {24'h0, err_count}, 32'd1);
        chk("b2b_b_ok", {16'h0, ok_count}, 32'd2);
        drive(1'b1, 1'b1);

        send_frame(1'b1, 32'hDEADBEEF, 8'h5A, 1'b0, 1'b0);
        chk("ferr_pulse", {31'h0, frame_err}, 32'h1);
        chk("ferr_no_valid", {31'h0, rx_valid}, 32'h0);
        chk("ferr_data_kept", rx_data, 32'h00000080);
        chk("ferr_err", {24'h0, err_count}, 32'd2);
        drive(1'b1, 1'b1);
        chk("ferr_drop", {31'h0, frame_err}, 32'h0);
        send_frame(1'b0, 32'h00000001, 8'h07, 1'b1, 1'b0);
        chk("ferr_next_valid", {31'h0, rx_valid}, 32'h1);
        chk("ferr_next_data", rx_data, 32'h00000001);
        chk("ferr_next_mode", {31'h0, rx_mode}, 32'h0);
        chk("ferr_next_ok", {16'h0, ok_count}, 32'd3);
        drive(1'b1, 1'b1);

        send_frame(1'b1, 32'h00000001, 8'h07, 1'b1, 1'b1);
        chk("rnd_valid", {31'h0, rx_valid}, 32'h1);
        chk("rnd_crc_err", {31'h0, crc_err}, 32'h0);
        chk("rnd_data", rx_data, 32'h00000001);
        chk("rnd_ok", {16'h0, ok_count}, 32'd4);
        drive(1'b1, 1'b0);
        chk("rnd_valid_drop_disabled", {31'h0, rx_valid}, 32'h0);
        chk("no_early_pulse", n_early, 0);

        f = {1'b0, 1'b1, 32'h12345678, 8'h00, 1'b1};
        for (int i = 42; i > 20; i--) drive(f[i], 1'b1);
        reset = 1'b1;
        drive(f[20], 1'b1);
        reset = 1'b0;
        chk("rst_mid_busy", {31'h0, busy}, 32'h0);
        chk("rst_mid_pulses", {29'h0, rx_valid, crc_err, frame_err}, 32'h0);
        chk("rst_mid_data", rx_data, 32'h0);
        chk("rst_mid_mode_crc", {23'h0, rx_mode, rx_crc}, 32'h0);
        chk("rst_mid_counts", {ok_count, 8'h0, err_count}, 32'h0);
        drive(1'b1, 1'b1);
        chk("rst_mid_idle", {31'h0, busy}, 32'h0);
        send_frame(1'b1, 32'h00000001, 8'h07, 1'b1, 1'b0);
        chk("rst_next_valid", {31'h0, rx_valid}, 32'h1);
        chk("rst_next_data", rx_data, 32'h00000001);
        chk("rst_next_ok", {16'h0, ok_count}, 32'd1);

        for (int i = 0; i < 254; i++) send_frame(1'b0, 32'h00000001, 8'h00, 1'b1, 1'b0);
        chk("sat_254", {24'h0, err_count}, 32'hFE);
        for (int i = 0; i < 6; i++) send_frame(1'b0, 32'h00000001, 8'h00, 1'b1, 1'b0);
        chk("sat_crc_err", {31'h0, crc_err}, 32'h1);
        chk("sat_err", {24'h0, err_count}, 32'hFF);
        chk("sat_ok_kept", {16'h0, ok_count}, 32'd1);
        drive(1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
